// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed address/data bus master.
// Holds the FSM encoding, default bus timing and the RTC register map.
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_SETUP,
    S_ADDR_STROBE,
    S_ADDR_HOLD,
    S_TURN,
    S_DATA_SETUP,
    S_DATA_STROBE,
    S_DATA_HOLD,
    S_DONE
  } state_t;

  localparam int DEF_T_SETUP = 4;
  localparam int DEF_T_PULSE = 8;
  localparam int DEF_T_HOLD  = 4;
  localparam int DEF_T_TURN  = 4;

  localparam logic [7:0] ADDR_SEG  = 8'h21;
  localparam logic [7:0] ADDR_MIN  = 8'h22;
  localparam logic [7:0] ADDR_HORA = 8'h23;
  localparam logic [7:0] ADDR_DIA  = 8'h24;
  localparam logic [7:0] ADDR_MES  = 8'h25;
  localparam logic [7:0] ADDR_ANO  = 8'h26;
  localparam logic [7:0] ADDR_ST   = 8'h41;
  localparam logic [7:0] ADDR_MT   = 8'h42;
  localparam logic [7:0] ADDR_HT   = 8'h43;

  // A state lasting N cycles starts its countdown at N-1 and leaves on zero.
  function automatic logic [7:0] timer_load(input int cycles);
    return 8'(cycles - 1);
  endfunction

endpackage

// File: rtl/rtc_bus_timer.sv
// Loadable 8-bit down-counter with zero flag; stops at zero until reloaded.
module rtc_bus_timer (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic       o_zero
);

  logic [7:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != 8'd0) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_zero = (r_count == 8'd0);

endmodule

// File: rtl/rtc_bus_master.sv
// Physical-side master for the RTC multiplexed AD bus: one address write followed by
// one data read or write per accepted start, with a single-cycle done pulse at the end.
module rtc_bus_master
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_PULSE = DEF_T_PULSE,
  parameter int T_HOLD  = DEF_T_HOLD,
  parameter int T_TURN  = DEF_T_TURN
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_wr_nrd,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wr_data,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rd_data,
  output logic       o_rtc_cs_n,
  output logic       o_rtc_rd_n,
  output logic       o_rtc_wr_n,
  output logic       o_rtc_ad_n,
  output logic [7:0] o_ad_out,
  output logic       o_ad_oe,
  input  logic [7:0] i_ad_in
);

  state_t     r_state;
  state_t     w_state_next;

  logic       r_wr_nrd;
  logic [7:0] r_addr;
  logic [7:0] r_wr_data;
  logic [7:0] r_rd_data;

  logic       r_cs_n, r_rd_n, r_wr_n, r_ad_n, r_ad_oe, r_busy, r_done;
  logic [7:0] r_ad_out;

  logic       w_cs_n, w_rd_n, w_wr_n, w_ad_n, w_ad_oe, w_busy, w_done;
  logic [7:0] w_ad_out;

  logic       w_wr_nrd;
  logic [7:0] w_addr;
  logic [7:0] w_wr_data;

  logic       w_timer_load;
  logic [7:0] w_timer_val;
  logic       w_timer_zero;

  rtc_bus_timer u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_timer_load),
    .i_load_val (w_timer_val),
    .o_zero     (w_timer_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The timer is reloaded on every state change with the new state's duration.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:        if (i_start)      w_state_next = S_ADDR_SETUP;
      S_ADDR_SETUP:  if (w_timer_zero) w_state_next = S_ADDR_STROBE;
      S_ADDR_STROBE: if (w_timer_zero) w_state_next = S_ADDR_HOLD;
      S_ADDR_HOLD:   if (w_timer_zero) w_state_next = S_TURN;
      S_TURN:        if (w_timer_zero) w_state_next = S_DATA_SETUP;
      S_DATA_SETUP:  if (w_timer_zero) w_state_next = S_DATA_STROBE;
      S_DATA_STROBE: if (w_timer_zero) w_state_next = S_DATA_HOLD;
      S_DATA_HOLD:   if (w_timer_zero) w_state_next = S_DONE;
      S_DONE:                          w_state_next = S_IDLE;
      default:                         w_state_next = S_IDLE;
    endcase

    w_timer_load = (w_state_next != r_state);
    case (w_state_next)
      S_ADDR_SETUP, S_DATA_SETUP:   w_timer_val = timer_load(T_SETUP);
      S_ADDR_STROBE, S_DATA_STROBE: w_timer_val = timer_load(T_PULSE);
      S_ADDR_HOLD, S_DATA_HOLD:     w_timer_val = timer_load(T_HOLD);
      S_TURN:                       w_timer_val = timer_load(T_TURN);
      default:                      w_timer_val = 8'd0;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with the state.
  assign w_wr_nrd  = (r_state == S_IDLE) ? i_wr_nrd  : r_wr_nrd;
  assign w_addr    = (r_state == S_IDLE) ? i_addr    : r_addr;
  assign w_wr_data = (r_state == S_IDLE) ? i_wr_data : r_wr_data;

  always_comb begin
    w_cs_n   = 1'b1;
    w_rd_n   = 1'b1;
    w_wr_n   = 1'b1;
    w_ad_n   = 1'b0;
    w_ad_oe  = 1'b0;
    w_ad_out = 8'h00;
    w_busy   = 1'b1;
    w_done   = 1'b0;
    case (w_state_next)
      S_IDLE: w_busy = 1'b0;
      S_ADDR_SETUP, S_ADDR_STROBE, S_ADDR_HOLD: begin
        w_cs_n   = 1'b0;
        w_ad_oe  = 1'b1;
        w_ad_out = w_addr;
        w_wr_n   = (w_state_next != S_ADDR_STROBE);
      end
      S_TURN: w_ad_n = 1'b1;
      S_DATA_SETUP, S_DATA_STROBE, S_DATA_HOLD: begin
        w_cs_n   = 1'b0;
        w_ad_n   = 1'b1;
        w_ad_oe  = w_wr_nrd;
        w_ad_out = w_wr_nrd ? w_wr_data : 8'h00;
        if (w_state_next == S_DATA_STROBE) begin
          w_wr_n = ~w_wr_nrd;
          w_rd_n = w_wr_nrd;
        end
      end
      S_DONE: begin
        w_ad_n = 1'b1;
        w_done = 1'b1;
      end
      default: w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cs_n   <= 1'b1;
      r_rd_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_ad_n   <= 1'b0;
      r_ad_oe  <= 1'b0;
      r_ad_out <= 8'h00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_cs_n   <= w_cs_n;
      r_rd_n   <= w_rd_n;
      r_wr_n   <= w_wr_n;
      r_ad_n   <= w_ad_n;
      r_ad_oe  <= w_ad_oe;
      r_ad_out <= w_ad_out;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  // Read data is captured at the edge that closes the final read strobe cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_nrd  <= 1'b0;
      r_addr    <= 8'h00;
      r_wr_data <= 8'h00;
      r_rd_data <= 8'h00;
    end else begin
      if (r_state == S_IDLE && i_start) begin
        r_wr_nrd  <= i_wr_nrd;
        r_addr    <= i_addr;
        r_wr_data <= i_wr_data;
      end
      if (r_state == S_DATA_STROBE && w_timer_zero && !r_wr_nrd) begin
        r_rd_data <= i_ad_in;
      end
    end
  end

  assign o_rtc_cs_n = r_cs_n;
  assign o_rtc_rd_n = r_rd_n;
  assign o_rtc_wr_n = r_wr_n;
  assign o_rtc_ad_n = r_ad_n;
  assign o_ad_oe    = r_ad_oe;
  assign o_ad_out   = r_ad_out;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_rd_data  = r_rd_data;

endmodule

// File: tb/tb_rtc_bus_master.sv
// Self-checking bench for rtc_bus_master: table vectors, random transactions against a
// timeline model, and hand sequences for overlap, held start, reset and minimum timing.
module tb_rtc_bus_master;

  logic       clk;
  logic       rstN;
  logic       start;
  logic       wrNrd;
  logic [7:0] addr;
  logic [7:0] wrData;
  logic [7:0] busVal;

  logic       busyA, doneA, csNA, rdNA, wrNA, adNA, oeA;
  logic [7:0] rdDataA, adOutA, adInA;
  logic       busyB, doneB, csNB, rdNB, wrNB, adNB, oeB;
  logic [7:0] rdDataB, adOutB, adInB;

  int testsRun = 0;
  int testsFailed = 0;
  logic [7:0] expRd [2];

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] bus;
    logic [7:0] expRdEnd;
    int         expDone;
  } vec_t;

  vec_t vecs [4];

  rtc_bus_master dutA (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_wr_nrd(wrNrd),
    .i_addr(addr), .i_wr_data(wrData),
    .o_busy(busyA), .o_done(doneA), .o_rd_data(rdDataA),
    .o_rtc_cs_n(csNA), .o_rtc_rd_n(rdNA), .o_rtc_wr_n(wrNA), .o_rtc_ad_n(adNA),
    .o_ad_out(adOutA), .o_ad_oe(oeA), .i_ad_in(adInA)
  );

  rtc_bus_master #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_TURN(1)) dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_wr_nrd(wrNrd),
    .i_addr(addr), .i_wr_data(wrData),
    .o_busy(busyB), .o_done(doneB), .o_rd_data(rdDataB),
    .o_rtc_cs_n(csNB), .o_rtc_rd_n(rdNB), .o_rtc_wr_n(wrNB), .o_rtc_ad_n(adNB),
    .o_ad_out(adOutB), .o_ad_oe(oeB), .i_ad_in(adInB)
  );

  // The RTC only returns busVal while a read strobe is low; otherwise the bus floats to junk.
  assign adInA = (!rdNA) ? busVal : ~busVal;
  assign adInB = (!rdNB) ? busVal : ~busVal;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] getAct(input int sel);
    if (sel == 0)
      return {9'd0, csNA, rdNA, wrNA, adNA, oeA, busyA, doneA, (oeA ? adOutA : 8'h00), rdDataA};
    return {9'd0, csNB, rdNB, wrNB, adNB, oeB, busyB, doneB, (oeB ? adOutB : 8'h00), rdDataB};
  endfunction

  // Expected pins at cycle t after acceptance, derived from the phase durations on a timeline.
  function automatic logic [31:0] modelOut(input int t, input int s, input int p, input int h,
                                           input int tr, input bit wr, input logic [7:0] a,
                                           input logic [7:0] d, input logic [7:0] rdOld,
                                           input logic [7:0] rdNew, output logic [31:0] mask);
    int addrEnd, strobeA0, strobeA1, turnEnd, dataStart, strobeD0, strobeD1, dataEnd;
    logic cs, rd, we, adn, oe, busy, dn;
    logic [7:0] ao, rdv;
    strobeA0  = s;
    strobeA1  = s + p;
    addrEnd   = s + p + h;
    turnEnd   = addrEnd + tr;
    dataStart = turnEnd;
    strobeD0  = dataStart + s;
    strobeD1  = strobeD0 + p;
    dataEnd   = strobeD1 + h;
    cs = 1; rd = 1; we = 1; adn = 0; oe = 0; busy = 0; dn = 0; ao = 8'h00;
    mask = 32'h007F_FFFF;
    if (t >= 1 && t <= addrEnd) begin
      cs = 0; oe = 1; ao = a; busy = 1;
      we = !(t > strobeA0 && t <= strobeA1);
    end else if (t >= 1 && t <= turnEnd) begin
      busy = 1; adn = 1;
    end else if (t >= 1 && t <= dataEnd) begin
      cs = 0; busy = 1; adn = 1; oe = wr; ao = wr ? d : 8'h00;
      if (t > strobeD0 && t <= strobeD1) begin
        if (wr) we = 0; else rd = 0;
      end
    end else if (t == dataEnd + 1) begin
      busy = 1; dn = 1; mask[19] = 1'b0;
    end else begin
      mask[19] = 1'b0;
    end
    rdv = (!wr && t > strobeD1) ? rdNew : rdOld;
    return {9'd0, cs, rd, we, adn, oe, busy, dn, ao, rdv};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp,
                             input logic [31:0] mask);
    testsRun++;
    if ((act & mask) !== (exp & mask)) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h (mask %h)", name, act & mask, exp & mask, mask);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit wr, input logic [7:0] a,
                               input logic [7:0] d, input logic [7:0] bus);
    start  = st;
    wrNrd  = wr;
    addr   = a;
    wrData = d;
    busVal = bus;
  endtask

  // Runs one transaction on the chosen DUT, comparing every cycle against the model.
  // Extra start pulses are driven so that the edge closing cycle pN samples start=1.
  task automatic runTxn(input int sel, input bit wr, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] bus, input int p1, input int p2, input int p3,
                        output int doneAt, output logic [7:0] rdEnd);
    int s, p, h, tr, doneT;
    logic [31:0] exp, mask, act;
    logic [7:0] rdNew;
    if (sel == 0) begin s = 4; p = 8; h = 4; tr = 4; end
    else begin s = 1; p = 1; h = 1; tr = 1; end
    doneT = 2 * (s + p + h) + tr + 1;
    rdNew = wr ? expRd[sel] : bus;
    doneAt = 0;
    @(negedge clk);
    applyStimulus(1'b1, wr, a, d, bus);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, ~wr, 8'($urandom), 8'($urandom), bus);
    for (int t = 1; t <= doneT + 2; t++) begin
      @(negedge clk);
      act = getAct(sel);
      exp = modelOut(t, s, p, h, tr, wr, a, d, expRd[sel], rdNew, mask);
      checkOutput($sformatf("dut%0d cycle %0d", sel, t), act, exp, mask);
      if (act[16] && doneAt == 0) doneAt = t;
      start = (t == p1 || t == p2 || t == p3);
    end
    start = 1'b0;
    rdEnd = act[7:0];
    expRd[sel] = rdNew;
  endtask

  initial begin : main
    int doneAt;
    logic [7:0] rdEnd;
    int doneCnt, firstDone, secondDone, secondSetup;

    vecs[0] = '{wr: 1'b1, addr: 8'h21, data: 8'h59, bus: 8'h00, expRdEnd: 8'h00, expDone: 37};
    vecs[1] = '{wr: 1'b0, addr: 8'h22, data: 8'h11, bus: 8'h23, expRdEnd: 8'h23, expDone: 37};
    vecs[2] = '{wr: 1'b1, addr: 8'h43, data: 8'hA5, bus: 8'h77, expRdEnd: 8'h23, expDone: 37};
    vecs[3] = '{wr: 1'b0, addr: 8'hFF, data: 8'h00, bus: 8'hC4, expRdEnd: 8'hC4, expDone: 37};

    rstN = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    expRd[0] = 8'h00;
    expRd[1] = 8'h00;
    #12;
    checkOutput("reset A", {9'd0, csNA, rdNA, wrNA, adNA, oeA, busyA, doneA, adOutA, rdDataA},
                32'h0070_0000, 32'h007F_FFFF);
    checkOutput("reset B", {9'd0, csNB, rdNB, wrNB, adNB, oeB, busyB, doneB, adOutB, rdDataB},
                32'h0070_0000, 32'h007F_FFFF);
    @(negedge clk);
    rstN = 1'b1;

    foreach (vecs[i]) begin
      runTxn(0, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].bus, 0, 0, 0, doneAt, rdEnd);
      checkOutput($sformatf("vec%0d done cycle", i), 32'(doneAt), 32'(vecs[i].expDone), '1);
      checkOutput($sformatf("vec%0d rd_data", i), {24'd0, rdEnd}, {24'd0, vecs[i].expRdEnd}, '1);
    end

    for (int i = 0; i < 10; i++) begin
      runTxn(0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
             0, 0, 0, doneAt, rdEnd);
      checkOutput($sformatf("rand%0d done cycle", i), 32'(doneAt), 32'd37, '1);
    end

    // Start pulses mid-transaction, on the DONE-entry edge and during DONE must be ignored.
    runTxn(0, 1'b0, 8'h24, 8'h00, 8'h3E, 5, 36, 37, doneAt, rdEnd);
    checkOutput("overlap done cycle", 32'(doneAt), 32'd37, '1);

    // Held start: back-to-back reads, two done pulses, second address phase 2 cycles after done.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'h25, 8'h00, 8'h5A);
    @(posedge clk);
    doneCnt = 0; firstDone = 0; secondDone = 0; secondSetup = 0;
    for (int t = 1; t <= 80; t++) begin
      @(negedge clk);
      if (doneA) begin
        doneCnt++;
        if (firstDone == 0) firstDone = t; else if (secondDone == 0) secondDone = t;
      end
      if (firstDone != 0 && t > firstDone && secondSetup == 0 && !csNA) secondSetup = t;
      if (t == 38) busVal = 8'hA6;
      if (t == 39) start = 1'b0;
    end
    checkOutput("held done count", 32'(doneCnt), 32'd2, '1);
    checkOutput("held first done", 32'(firstDone), 32'd37, '1);
    checkOutput("held second setup", 32'(secondSetup), 32'd39, '1);
    checkOutput("held second done", 32'(secondDone), 32'd75, '1);
    checkOutput("held rd_data", {24'd0, rdDataA}, 32'h0000_00A6, '1);
    expRd[0] = 8'hA6;

    // Reset during the data read strobe clears the pins immediately, with no done pulse.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'h26, 8'h00, 8'h3C);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int t = 1; t <= 27; t++) @(negedge clk);
    checkOutput("pre-reset rd_n low", {31'd0, rdNA}, 32'd0, '1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async reset pins",
                {9'd0, csNA, rdNA, wrNA, adNA, oeA, busyA, doneA, adOutA, rdDataA},
                32'h0070_0000, 32'h007F_FFFF);
    @(negedge clk);
    checkOutput("held reset no done", {31'd0, doneA}, 32'd0, '1);
    rstN = 1'b1;
    expRd[0] = 8'h00;
    expRd[1] = 8'h00;
    runTxn(0, 1'b1, 8'h21, 8'h07, 8'h00, 0, 0, 0, doneAt, rdEnd);
    checkOutput("post-reset done cycle", 32'(doneAt), 32'd37, '1);

    // Minimum timing instance: single-cycle strobes and done at cycle 8.
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    expRd[0] = 8'h00;
    expRd[1] = 8'h00;
    runTxn(1, 1'b1, 8'h55, 8'h66, 8'h00, 0, 0, 0, doneAt, rdEnd);
    checkOutput("min write done cycle", 32'(doneAt), 32'd8, '1);
    runTxn(1, 1'b0, 8'h42, 8'h00, 8'h99, 0, 0, 0, doneAt, rdEnd);
    checkOutput("min read done cycle", 32'(doneAt), 32'd8, '1);
    checkOutput("min read rd_data", {24'd0, rdEnd}, 32'h0000_0099, '1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
